pe_ctx_seq: RTL and testbench
=============================

# pe_ctx_seq

Per-PE context sequencer for the CGRA tile. It holds a small context memory of control words and, once started, replays a programmed number of contexts for a programmed number of iterations. Each cycle it drives the control fields consumed by the directly downstream PE register/routing stage: mux selects, register-file addresses, FU operand selects, write-back and load enables. When it is not running, it emits a NOP word so that the register file never takes a spurious write.

## Interface
Parameters:
- CTX_DEPTH, 16: number of context words (power of 2).
- AW, 4: context address width, equal to log2(CTX_DEPTH).
- IW, 16: iteration counter width.

Ports:
- Clock and reset:
  - CLK  in  1  clock; all state updates on posedge.
  - RST  in  1  reset. One clock; reset is synchronous and active-high.
- Configuration and run control:
  - cfg_we  in  1  write a context word.
  - cfg_addr  in  AW  context address for the write.
  - cfg_data  in  59  context word to write.
  - start  in  1  begin run; sampled only in IDLE.
  - ctx_len  in  AW+1  contexts per iteration, 0..CTX_DEPTH; sampled at start.
  - iter_cnt  in  IW  iteration count; sampled at start.
  - stall  in  1  freeze sequencing for this cycle.
  - busy  out  1  high in RUN.
  - done  out  1  one-cycle pulse at end of run.
  - cur_iter  out  IW  index of the current iteration.
- Control fields to the register stage:
  - control_in  out  9  register stage input-mux select.
  - control_out  out  9  register stage output-port enables.
  - control_reg_1, control_reg_2  out  6  FU operand read addresses.
  - control_put_in, control_put_out, control_send  out  6  write and send addresses.
  - control_pe2fu_1, control_pe2fu_2  out  4  FU operand bypass selects.
  - write_back, ld, ld_write  out  1  write enables.

## Operation
- Context word packing, MSB first: control_in[58:50], control_out[49:41], control_reg_1[40:35], control_reg_2[34:29], control_put_in[28:23], control_put_out[22:17], control_send[16:11], control_pe2fu_1[10:7], control_pe2fu_2[6:3], write_back[2], ld[1], ld_write[0].
- NOP word: all fields 0 except ld=1, ld_write=0, write_back=0. This suppresses both register-file write paths.
- States:
  - IDLE: cfg_we writes memory[cfg_addr]. When start=1:
    - If ctx_len==0 or iter_cnt==0, go to DONE.
    - Otherwise latch ctx_len and iter_cnt, set pc=0 and iter=0, and go to RUN.
  - RUN: drive memory[pc]. On each non-stalled cycle:
    - If pc < len-1, pc++.
    - Else if iter < iters-1, set pc=0 and iter++.
    - Else go to DONE.
  - DONE: done=1 for one cycle, then go to IDLE.
- cfg_we outside IDLE is ignored, and the memory is unchanged. start outside IDLE is ignored.
- Stall in RUN: pc and iter hold, and outputs are forced to the NOP word. The context is re-driven in full on the first unstalled cycle.
- cur_iter equals iter in RUN and 0 otherwise.

## Timing
- All outputs are registered.
- Reset: state=IDLE, pc=0, iter=0, busy=0, done=0, cur_iter=0, control outputs at the NOP word. Context memory is not cleared.
- start accepted at edge t: ctx[0] is on the outputs and busy=1 from edge t+1.
- No stalls: context k of iteration i is on the outputs at t+1+i·len+k.
  - The last context holds for one cycle.
  - DONE is at t+1+len·iters, with outputs at NOP and busy=0.
  - IDLE follows on the next cycle.
- Degenerate start (len or iters zero): done is pulsed at t+1 and no context is emitted.
- A config write at edge t is readable by a run starting at t+1 or later.
- RST asserted mid-run: the next edge returns to IDLE with NOP outputs and no done pulse.
- A start asserted in the same cycle as RST is ignored.
- pc wraps only via the ctx_len compare and never exceeds CTX_DEPTH-1. The iter counter width matches iter_cnt, so it cannot overflow.

## Structure
- Package pe_ctx_pkg holds:
  - field widths and bit positions
  - the 59-bit ctx_word type
  - the NOP constant
  - the state enum (IDLE, RUN, DONE)
- Sub-module pe_ctx_mem: CTX_DEPTH×59 synchronous-write, registered-read memory. The sequencer presents the next pc so that the registered read lines up with the output register.

## Test plan
1. Reset, then idle: outputs equal the NOP word (ld=1, all else 0), and busy=0, done=0.
2. Load ctx[0..2] with distinct control_put_in values 5, 6, 7; start with len=3, iters=2 → control_put_in follows 5,6,7,5,6,7 on consecutive cycles; cur_iter follows 0,0,0,1,1,1; done pulses exactly one cycle after the last 7.
3. Same program with stall high for 2 cycles during context 1 of iteration 0 → 2 NOP cycles appear, then 6,7,5,6,7; done is delayed by 2 cycles.
4. start with iters=0, then separately with len=0 → done at t+1, and no non-NOP output is ever driven.
5. Assert RST during iteration 1 → the next cycle shows NOP outputs, busy=0, and no done pulse; a restart replays the original contexts, confirming memory was retained.
6. Assert cfg_we to ctx[1] and start together while in RUN → both are ignored, and the current run's outputs are unchanged.

Source files
------------

// File: rtl/pe_ctx_pkg.sv
// Shared definitions for the per-PE context sequencer: context word layout,
// the NOP word and the sequencer state encoding.
package pe_ctx_pkg;

  localparam int CTX_W  = 59;

  // Field widths
  localparam int IN_W   = 9;
  localparam int OUT_W  = 9;
  localparam int REG_W  = 6;
  localparam int ADDR_W = 6;
  localparam int BYP_W  = 4;

  // Field LSB positions inside the context word
  localparam int IN_LSB     = 50;
  localparam int OUT_LSB    = 41;
  localparam int REG1_LSB   = 35;
  localparam int REG2_LSB   = 29;
  localparam int PUTIN_LSB  = 23;
  localparam int PUTOUT_LSB = 17;
  localparam int SEND_LSB   = 11;
  localparam int P2F1_LSB   = 7;
  localparam int P2F2_LSB   = 3;
  localparam int WB_BIT     = 2;
  localparam int LD_BIT     = 1;
  localparam int LDW_BIT    = 0;

  typedef struct packed {
    logic [IN_W-1:0]   control_in;
    logic [OUT_W-1:0]  control_out;
    logic [REG_W-1:0]  control_reg_1;
    logic [REG_W-1:0]  control_reg_2;
    logic [ADDR_W-1:0] control_put_in;
    logic [ADDR_W-1:0] control_put_out;
    logic [ADDR_W-1:0] control_send;
    logic [BYP_W-1:0]  control_pe2fu_1;
    logic [BYP_W-1:0]  control_pe2fu_2;
    logic              write_back;
    logic              ld;
    logic              ld_write;
  } ctx_word_t;

  // ld=1 with both write enables low keeps the register file untouched.
  localparam ctx_word_t CTX_NOP = ctx_word_t'(CTX_W'(1) << LD_BIT);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

endpackage

// File: rtl/pe_ctx_mem.sv
// Context memory: synchronous write, registered read. The read register doubles
// as the sequencer's control-output register, so it loads NOP when told to.
module pe_ctx_mem
  import pe_ctx_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [CTX_W-1:0] wr_data_i,
  input  logic [AW-1:0]    rd_addr_i,
  input  logic             rd_nop_i,
  output logic [CTX_W-1:0] rd_data_o
);

  logic [CTX_W-1:0] mem_q [DEPTH];
  logic [CTX_W-1:0] rd_data_q;

  // NOTE: the array is deliberately not reset; contexts must survive RST and a
  // resettable array would force flops instead of a RAM macro.
  always_ff @(posedge CLK) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST || rd_nop_i) begin
      rd_data_q <= CTX_NOP;
    end else begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/pe_ctx_seq.sv
// Per-PE context sequencer: replays ctx_len contexts for iter_cnt iterations and
// drives the register stage control fields, emitting NOP whenever not running.
module pe_ctx_seq
  import pe_ctx_pkg::*;
#(
  parameter int CTX_DEPTH = 16,
  parameter int AW        = 4,
  parameter int IW        = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             cfg_we,
  input  logic [AW-1:0]    cfg_addr,
  input  logic [CTX_W-1:0] cfg_data,
  input  logic             start,
  input  logic [AW:0]      ctx_len,
  input  logic [IW-1:0]    iter_cnt,
  input  logic             stall,
  output logic             busy,
  output logic             done,
  output logic [IW-1:0]    cur_iter,
  output logic [8:0]       control_in,
  output logic [8:0]       control_out,
  output logic [5:0]       control_reg_1,
  output logic [5:0]       control_reg_2,
  output logic [5:0]       control_put_in,
  output logic [5:0]       control_put_out,
  output logic [5:0]       control_send,
  output logic [3:0]       control_pe2fu_1,
  output logic [3:0]       control_pe2fu_2,
  output logic             write_back,
  output logic             ld,
  output logic             ld_write
);

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [IW-1:0] iter_q, iter_d;
  logic [AW:0]   len_q, len_d;
  logic [IW-1:0] iters_q, iters_d;
  logic          emit;
  logic          mem_we;
  logic [CTX_W-1:0] rd_word;

  // Next-state lookahead: pc_d is the address the memory reads at this edge, so
  // the context lands on the outputs in the same cycle pc takes its new value.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    iter_d  = iter_q;
    len_d   = len_q;
    iters_d = iters_q;
    emit    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (ctx_len == '0 || iter_cnt == '0) begin
            state_d = DONE;
          end else begin
            len_d   = ctx_len;
            iters_d = iter_cnt;
            pc_d    = '0;
            iter_d  = '0;
            state_d = RUN;
            emit    = 1'b1;
          end
        end
      end
      RUN: begin
        if (!stall) begin
          if ({1'b0, pc_q} < len_q - (AW+1)'(1)) begin
            pc_d = pc_q + AW'(1);
            emit = 1'b1;
          end else if (iter_q < iters_q - IW'(1)) begin
            pc_d   = '0;
            iter_d = iter_q + IW'(1);
            emit   = 1'b1;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      pc_q     <= '0;
      iter_q   <= '0;
      len_q    <= '0;
      iters_q  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      cur_iter <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      iter_q   <= iter_d;
      len_q    <= len_d;
      iters_q  <= iters_d;
      busy     <= (state_d == RUN);
      done     <= (state_d == DONE);
      cur_iter <= (state_d == RUN) ? iter_d : '0;
    end
  end

  assign mem_we = cfg_we && (state_q == IDLE) && !RST;

  pe_ctx_mem #(
    .DEPTH (CTX_DEPTH),
    .AW    (AW)
  ) u_mem (
    .CLK       (CLK),
    .RST       (RST),
    .wr_en_i   (mem_we),
    .wr_addr_i (cfg_addr),
    .wr_data_i (cfg_data),
    .rd_addr_i (pc_d),
    .rd_nop_i  (!emit),
    .rd_data_o (rd_word)
  );

  assign control_in      = rd_word[IN_LSB     +: IN_W];
  assign control_out     = rd_word[OUT_LSB    +: OUT_W];
  assign control_reg_1   = rd_word[REG1_LSB   +: REG_W];
  assign control_reg_2   = rd_word[REG2_LSB   +: REG_W];
  assign control_put_in  = rd_word[PUTIN_LSB  +: ADDR_W];
  assign control_put_out = rd_word[PUTOUT_LSB +: ADDR_W];
  assign control_send    = rd_word[SEND_LSB   +: ADDR_W];
  assign control_pe2fu_1 = rd_word[P2F1_LSB   +: BYP_W];
  assign control_pe2fu_2 = rd_word[P2F2_LSB   +: BYP_W];
  assign write_back      = rd_word[WB_BIT];
  assign ld              = rd_word[LD_BIT];
  assign ld_write        = rd_word[LDW_BIT];

endmodule

// File: tb/tb_pe_ctx_seq.sv
// Bench for pe_ctx_seq: a queue-based model of the replay schedule checked every
// cycle, directed scenarios with literal expectations, then randomized runs.
module tb_pe_ctx_seq;
  import pe_ctx_pkg::*;

  localparam int CTX_DEPTH = 16;
  localparam int AW        = 4;
  localparam int IW        = 16;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic             RST = 1'b1;
  logic             cfg_we = 1'b0;
  logic [AW-1:0]    cfg_addr = '0;
  logic [CTX_W-1:0] cfg_data = '0;
  logic             start = 1'b0;
  logic [AW:0]      ctx_len = '0;
  logic [IW-1:0]    iter_cnt = '0;
  logic             stall = 1'b0;
  logic             busy, done;
  logic [IW-1:0]    cur_iter;
  logic [8:0]       control_in, control_out;
  logic [5:0]       control_reg_1, control_reg_2;
  logic [5:0]       control_put_in, control_put_out, control_send;
  logic [3:0]       control_pe2fu_1, control_pe2fu_2;
  logic             write_back, ld, ld_write;

  pe_ctx_seq #(.CTX_DEPTH(CTX_DEPTH), .AW(AW), .IW(IW)) dut (
    .CLK(CLK), .RST(RST), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .start(start), .ctx_len(ctx_len), .iter_cnt(iter_cnt), .stall(stall),
    .busy(busy), .done(done), .cur_iter(cur_iter),
    .control_in(control_in), .control_out(control_out),
    .control_reg_1(control_reg_1), .control_reg_2(control_reg_2),
    .control_put_in(control_put_in), .control_put_out(control_put_out),
    .control_send(control_send), .control_pe2fu_1(control_pe2fu_1),
    .control_pe2fu_2(control_pe2fu_2), .write_back(write_back), .ld(ld),
    .ld_write(ld_write)
  );

  ctx_word_t dut_word;
  assign dut_word = {control_in, control_out, control_reg_1, control_reg_2,
                     control_put_in, control_put_out, control_send,
                     control_pe2fu_1, control_pe2fu_2, write_back, ld, ld_write};

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: a run is the flat list of (word, iteration) it must emit, in order.
  localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2;
  typedef struct {
    ctx_word_t w;
    int        it;
  } emit_t;

  ctx_word_t     shadow [CTX_DEPTH];
  emit_t         sched [$];
  int            m_mode = M_IDLE;
  ctx_word_t     m_word = CTX_NOP;
  logic          m_busy = 1'b0;
  logic          m_done = 1'b0;
  logic [IW-1:0] m_iter = '0;

  task automatic pop_emit();
    emit_t e;
    e      = sched.pop_front();
    m_word = e.w;
    m_iter = IW'(e.it);
    m_busy = 1'b1;
  endtask

  task automatic model_step();
    m_done = 1'b0;
    if (RST) begin
      m_mode = M_IDLE; sched.delete();
      m_word = CTX_NOP; m_busy = 1'b0; m_iter = '0;
      return;
    end
    case (m_mode)
      M_IDLE: begin
        m_word = CTX_NOP; m_busy = 1'b0; m_iter = '0;
        if (start) begin
          if (ctx_len == 0 || iter_cnt == 0) begin
            m_mode = M_DONE; m_done = 1'b1;
          end else begin
            for (int i = 0; i < int'(iter_cnt); i++)
              for (int k = 0; k < int'(ctx_len); k++)
                sched.push_back('{w: shadow[k], it: i});
            pop_emit();
            m_mode = M_RUN;
          end
        end
        if (cfg_we) shadow[cfg_addr] = ctx_word_t'(cfg_data);
      end
      M_RUN: begin
        if (stall) begin
          m_word = CTX_NOP;
        end else if (sched.size() > 0) begin
          pop_emit();
        end else begin
          m_mode = M_DONE; m_word = CTX_NOP; m_busy = 1'b0; m_iter = '0; m_done = 1'b1;
        end
      end
      default: begin
        m_mode = M_IDLE; m_word = CTX_NOP; m_busy = 1'b0; m_iter = '0;
      end
    endcase
  endtask

  task automatic tick();
    @(posedge CLK);
    model_step();
    @(negedge CLK);
    check("word", 64'(dut_word), 64'(m_word));
    check("busy", 64'(busy), 64'(m_busy));
    check("done", 64'(done), 64'(m_done));
    check("cur_iter", 64'(cur_iter), 64'(m_iter));
  endtask

  function automatic ctx_word_t rand_word();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return ctx_word_t'(r[CTX_W-1:0]);
  endfunction

  task automatic write_ctx(input int addr, input ctx_word_t w);
    cfg_we = 1'b1; cfg_addr = AW'(addr); cfg_data = w;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic start_run(input int len, input int iters);
    start = 1'b1; ctx_len = (AW+1)'(len); iter_cnt = IW'(iters);
    tick();
    start = 1'b0;
  endtask

  int exp_put2 [7]  = '{5, 6, 7, 5, 6, 7, 0};
  int exp_it2  [7]  = '{0, 0, 0, 1, 1, 1, 0};
  int exp_put3 [9]  = '{5, 0, 0, 6, 7, 5, 6, 7, 0};

  initial begin
    ctx_word_t w;

    // 1. Reset and idle
    tick();
    RST = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("idle_ld", 64'(ld), 64'(1));
    check("idle_word", 64'(dut_word), 64'(CTX_W'(2)));

    for (int a = 0; a < CTX_DEPTH; a++) write_ctx(a, rand_word());
    for (int a = 0; a < 3; a++) begin
      w = rand_word();
      w.control_put_in = 6'(5 + a);
      write_ctx(a, w);
    end

    // 2. Plain replay len=3 iters=2
    start_run(3, 2);
    for (int i = 0; i < 7; i++) begin
      if (i > 0) tick();
      check($sformatf("t2_put%0d", i), 64'(control_put_in), 64'(exp_put2[i]));
      check($sformatf("t2_iter%0d", i), 64'(cur_iter), 64'(exp_it2[i]));
      check($sformatf("t2_done%0d", i), 64'(done), 64'(i == 6));
    end
    tick();

    // 3. Two stall cycles after context 0
    start_run(3, 2);
    for (int i = 0; i < 9; i++) begin
      stall = (i == 1 || i == 2);
      if (i > 0) tick();
      check($sformatf("t3_put%0d", i), 64'(control_put_in), 64'(exp_put3[i]));
      check($sformatf("t3_done%0d", i), 64'(done), 64'(i == 8));
    end
    stall = 1'b0;
    tick();

    // 4. Degenerate starts
    start_run(3, 0);
    check("t4_iters0_done", 64'(done), 64'(1));
    check("t4_iters0_word", 64'(dut_word), 64'(CTX_NOP));
    tick();
    start_run(0, 2);
    check("t4_len0_done", 64'(done), 64'(1));
    check("t4_len0_busy", 64'(busy), 64'(0));
    tick();

    // 5. Reset during iteration 1, then replay
    start_run(3, 2);
    for (int i = 0; i < 3; i++) tick();
    check("t5_iter1", 64'(cur_iter), 64'(1));
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("t5_rst_busy", 64'(busy), 64'(0));
    check("t5_rst_word", 64'(dut_word), 64'(CTX_NOP));
    tick();
    check("t5_no_done", 64'(done), 64'(0));
    start_run(3, 2);
    check("t5_replay_put0", 64'(control_put_in), 64'(5));
    for (int i = 0; i < 7; i++) tick();

    // 6. cfg_we and start while running are ignored
    start_run(3, 2);
    tick();
    cfg_we = 1'b1; cfg_addr = AW'(1); cfg_data = rand_word();
    start = 1'b1; ctx_len = (AW+1)'(1); iter_cnt = IW'(1);
    tick();
    cfg_we = 1'b0; start = 1'b0;
    check("t6_put2", 64'(control_put_in), 64'(7));
    for (int i = 0; i < 5; i++) tick();
    start_run(3, 1);
    tick();
    check("t6_mem_kept", 64'(control_put_in), 64'(6));
    for (int i = 0; i < 3; i++) tick();

    // Randomized runs
    for (int run = 0; run < 40; run++) begin
      int cyc;
      for (int i = 0; i < int'($urandom_range(0, 3)); i++) begin
        cfg_we = 1'($urandom_range(0, 1)); cfg_addr = AW'($urandom());
        cfg_data = rand_word();
        tick();
      end
      cfg_we = 1'b0;
      start_run(int'($urandom_range(0, CTX_DEPTH)), int'($urandom_range(0, 3)));
      cyc = 0;
      while (m_mode != M_IDLE && cyc < 300) begin
        stall = ($urandom_range(0, 3) == 0);
        cfg_we = 1'($urandom_range(0, 1)); cfg_addr = AW'($urandom());
        cfg_data = rand_word();
        start = 1'($urandom_range(0, 1));
        ctx_len = (AW+1)'($urandom_range(1, CTX_DEPTH)); iter_cnt = IW'($urandom_range(1, 3));
        RST = ($urandom_range(0, 99) == 0);
        tick();
        cyc++;
      end
      stall = 1'b0; cfg_we = 1'b0; start = 1'b0; RST = 1'b0;
      check("run_timeout", 64'(m_mode), 64'(M_IDLE));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
